// File: rtl/updown_counter_7seg.sv
// Debounced up/down counter with parallel load, driven by raw active-low push-buttons,
// and a BCD seven-segment readout (active-low, gfedcba per digit).
module updown_counter_7seg #(
    parameter int           N         = 6,
    parameter int           DIGITS    = 2,
    parameter int           DEBOUNCE  = 4,
    parameter bit           SATURATE  = 1'b0,
    parameter logic [N-1:0] RESET_VAL = {N{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_increment,
    input  logic                btn_decrement,
    input  logic                btn_load,
    input  logic [N-1:0]        load_value,
    output logic [N-1:0]        count,
    output logic                zero,
    output logic                limit,
    output logic [7*DIGITS-1:0] seg
);

    localparam int NB       = 3;
    localparam int BTN_INC  = 0;
    localparam int BTN_DEC  = 1;
    localparam int BTN_LOAD = 2;

    localparam int             CW        = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0]  STAB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [N-1:0]   MAX_VAL   = '1;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] db;
    logic [NB-1:0] db_d1;
    logic [NB-1:0] press;
    logic [CW-1:0] stab [NB];
    logic          inc;
    logic          dec;
    logic [31:0]   rest;

    assign raw = {btn_load, btn_decrement, btn_increment};

    // All button flops reset to the released (high) level, so a button held
    // through reset is seen afterwards as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            db_d1 <= '1;
            // NOTE: the small stability-counter array is reset explicitly; it is
            // control state, not storage, so it must start from a known value.
            for (int i = 0; i < NB; i++) begin
                stab[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what turns sync1 -> sync2 into a real two-stage chain.
            sync1 <= raw;
            sync2 <= sync1;
            db_d1 <= db;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    stab[i] <= '0;
                end else if (stab[i] == STAB_LAST) begin
                    db[i]   <= sync2[i];
                    stab[i] <= '0;
                end else begin
                    stab[i] <= stab[i] + 1'b1;
                end
            end
        end
    end

    // Falling edge of the debounced level; releases produce nothing.
    assign press = db_d1 & ~db;
    assign inc   = press[BTN_INC] & ~press[BTN_DEC];
    assign dec   = press[BTN_DEC] & ~press[BTN_INC];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VAL;
            limit <= 1'b0;
        end else begin
            limit <= 1'b0;
            if (press[BTN_LOAD]) begin
                count <= load_value;
            end else if (inc) begin
                if (count == MAX_VAL) begin
                    limit <= 1'b1;
                    count <= SATURATE ? MAX_VAL : '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (dec) begin
                if (count == '0) begin
                    limit <= 1'b1;
                    count <= SATURATE ? '0 : MAX_VAL;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    assign zero = (count == '0);

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 7'b1000000;
            4'd1:    seg_pattern = 7'b1111001;
            4'd2:    seg_pattern = 7'b0100100;
            4'd3:    seg_pattern = 7'b0110000;
            4'd4:    seg_pattern = 7'b0011001;
            4'd5:    seg_pattern = 7'b0010010;
            4'd6:    seg_pattern = 7'b0000010;
            4'd7:    seg_pattern = 7'b1111000;
            4'd8:    seg_pattern = 7'b0000000;
            4'd9:    seg_pattern = 7'b0010000;
            default: seg_pattern = 7'b1111111;
        endcase
    endfunction

    // Peel off decimal digits least-significant first; no leading-zero blanking.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        seg  = '1;
        rest = 32'(count);
        for (int k = 0; k < DIGITS; k++) begin
            seg[7*k +: 7] = seg_pattern(4'(rest % 32'd10));
            rest          = rest / 32'd10;
        end
    end

endmodule
